// File: rtl/bench_pkg.sv
// Shared types for the benchmark sequencer: FSM states, expected-value table
// entry layout and default geometry.
package bench_pkg;

    localparam int DEF_XLEN       = 64;
    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_MAX_CHECKS = 16;
    localparam int DEF_RAW        = $clog2(DEF_NUM_REGS);
    localparam int DEF_IW         = $clog2(DEF_MAX_CHECKS);
    localparam int DEF_CW         = DEF_IW + 1;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        CHECK,
        DONE
    } state_t;

    // One table entry: register number, expected value and compare mask.
    typedef struct packed {
        logic [DEF_RAW-1:0]  rnum;
        logic [DEF_XLEN-1:0] val;
        logic [DEF_XLEN-1:0] mask;
    } entry_t;

endpackage

// File: rtl/bench_expect_table.sv
// Expected-value table: one synchronous write port, one combinational read
// port. Contents are deliberately not reset so they survive a sequencer reset.
module bench_expect_table
    import bench_pkg::*;
#(
    parameter int MAX_CHECKS = DEF_MAX_CHECKS,
    localparam int IW = $clog2(MAX_CHECKS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  entry_t        wentry,
    input  logic [IW-1:0] ridx,
    output entry_t        rentry
);

    entry_t mem [MAX_CHECKS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wentry;
        end
    end

    assign rentry = mem[ridx];

endmodule

// File: rtl/bench_sequencer.sv
// Benchmark sequencer: holds the processor in reset, runs it for a cycle
// budget, then checks register-file contents against the expected-value table.
module bench_sequencer
    import bench_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int MAX_CHECKS = DEF_MAX_CHECKS,
    parameter int CYC_W      = 16,
    parameter int RST_CYCLES = 2,
    localparam int RAW = $clog2(NUM_REGS),
    localparam int IW  = $clog2(MAX_CHECKS),
    localparam int CW  = IW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CYC_W-1:0] budget,
    input  logic             exp_we,
    input  logic [IW-1:0]    exp_idx,
    input  logic [RAW-1:0]   exp_reg,
    input  logic [XLEN-1:0]  exp_val,
    input  logic [XLEN-1:0]  exp_mask,
    input  logic [CW-1:0]    num_checks,
    output logic             proc_reset,
    output logic [RAW-1:0]   rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    err_cnt,
    output logic [IW-1:0]    fail_idx,
    output logic [XLEN-1:0]  fail_got,
    output logic [CYC_W-1:0] cyc_cnt
);

    localparam int HW = $clog2(RST_CYCLES + 1);

    state_t           state;
    logic [CYC_W-1:0] budget_q;
    logic [CW-1:0]    n_q;
    logic [CW-1:0]    iss_idx;
    logic [HW-1:0]    hold_cnt;
    logic             vld_p0, vld_p1, last_p0, last_p1;
    logic [XLEN-1:0]  val_p0, val_p1, mask_p0, mask_p1;
    logic [IW-1:0]    idx_p0, idx_p1;

    entry_t           wentry, rentry;
    logic             tbl_we, hold_end, enter_check, issue, mism, check_end;
    logic [CW-1:0]    issue_ptr;

    assign wentry      = '{rnum: exp_reg, val: exp_val, mask: exp_mask};
    assign tbl_we      = exp_we && (state == IDLE || state == DONE);
    assign hold_end    = (state == HOLD) && (hold_cnt == HW'(RST_CYCLES - 1));
    assign enter_check = (hold_end && budget_q == '0) ||
                         (state == RUN && cyc_cnt == budget_q - CYC_W'(1));
    assign issue_ptr   = (state == CHECK) ? iss_idx : '0;
    assign issue       = (enter_check && n_q != '0) || (state == CHECK && iss_idx < n_q);
    assign mism        = vld_p1 && (((rf_rdata ^ val_p1) & mask_p1) != '0);
    assign check_end   = (state == CHECK) && (n_q == '0 || (vld_p1 && last_p1));

    bench_expect_table #(.MAX_CHECKS(MAX_CHECKS)) u_table (
        .clk    (clk),
        .we     (tbl_we),
        .widx   (exp_idx),
        .wentry (wentry),
        .ridx   (issue_ptr[IW-1:0]),
        .rentry (rentry)
    );

    // p0: address issued to the RF with its entry; p1: RF data returns, compare
    always_ff @(posedge clk) begin
        if (issue) begin
            val_p0  <= rentry.val;
            mask_p0 <= rentry.mask;
            idx_p0  <= issue_ptr[IW-1:0];
        end
        val_p1  <= val_p0;
        mask_p1 <= mask_p0;
        idx_p1  <= idx_p0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            proc_reset <= 1'b1;
            rf_raddr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_idx   <= '0;
            fail_got   <= '0;
            cyc_cnt    <= '0;
            budget_q   <= '0;
            n_q        <= '0;
            iss_idx    <= '0;
            hold_cnt   <= '0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            last_p0    <= 1'b0;
            last_p1    <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            proc_reset <= 1'b1;
            rf_raddr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_idx   <= '0;
            fail_got   <= '0;
            cyc_cnt    <= '0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
            if (issue) begin
                rf_raddr <= rentry.rnum;
                vld_p0   <= 1'b1;
                last_p0  <= (issue_ptr == n_q - CW'(1));
                iss_idx  <= issue_ptr + CW'(1);
            end else begin
                vld_p0 <= 1'b0;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= HOLD;
                        budget_q   <= budget;
                        n_q        <= (num_checks > CW'(MAX_CHECKS)) ? CW'(MAX_CHECKS) : num_checks;
                        err_cnt    <= '0;
                        fail_idx   <= '0;
                        fail_got   <= '0;
                        cyc_cnt    <= '0;
                        hold_cnt   <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        proc_reset <= 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_end) begin
                        // A zero budget skips RUN and keeps the processor in reset.
                        if (budget_q == '0) begin
                            state <= CHECK;
                        end else begin
                            state      <= RUN;
                            proc_reset <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                RUN: begin
                    if (cyc_cnt != '1) begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                    if (enter_check) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mism) begin
                        err_cnt <= err_cnt + CW'(1);
                        if (err_cnt == '0) begin
                            fail_idx <= idx_p1;
                            fail_got <= rf_rdata;
                        end
                    end
                    if (check_end) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pass       <= (err_cnt == '0) && !mism;
                        proc_reset <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bench_sequencer.md
Name: bench_sequencer

Overview:
- Synthesizable, parametrised successor to the processor benchmark flow.
- Holds the pipelined processor in reset, then releases it for a programmable cycle budget.
- When the budget expires, walks a table of expected register values through a register-file read port and reports pass/fail, first-mismatch details and error count.
- Sits beside `pipelined_processor` in the FPGA/sim top. It drives the processor reset and has its own RF debug read port.

Parameters:
- XLEN, 64, register data width.
- NUM_REGS, 32, architectural registers; address width is log2(NUM_REGS).
- MAX_CHECKS, 16, depth of the expected-value table.
- CYC_W, 16, width of the cycle budget and cycle counter.
- RST_CYCLES, 2, cycles `proc_reset` is held after start.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- abort  in  1  returns to IDLE from any state.
- budget  in  CYC_W  run cycles; sampled on accepted start.
- exp_we  in  1  table write strobe.
- exp_idx  in  log2(MAX_CHECKS)  table entry index.
- exp_reg  in  log2(NUM_REGS)  register to check.
- exp_val  in  XLEN  expected value.
- exp_mask  in  XLEN  compare mask; 1 = bit checked.
- num_checks  in  log2(MAX_CHECKS)+1  valid entries; sampled on start.
- proc_reset  out  1  reset to the processor.
- rf_raddr  out  log2(NUM_REGS)  RF debug read address.
- rf_rdata  in  XLEN  RF data, valid one cycle after rf_raddr.
- busy  out  1  not IDLE and not DONE.
- done  out  1  level, high in DONE.
- pass  out  1  done and err_cnt==0.
- err_cnt  out  log2(MAX_CHECKS)+1  mismatches this run.
- fail_idx  out  log2(MAX_CHECKS)  first mismatching entry.
- fail_got  out  XLEN  rf_rdata at first mismatch.
- cyc_cnt  out  CYC_W  cycles spent in RUN.

Behaviour:
- Reset values:
  - state = IDLE.
  - proc_reset = 1.
  - rf_raddr, err_cnt, fail_idx, fail_got and cyc_cnt = 0.
  - busy, done and pass = 0.
  - Table contents are not reset; they are undefined until written.
- IDLE:
  - proc_reset = 1.
  - exp_we writes entry exp_idx (reg, val, mask) on the clock edge.
  - start latches budget and num_checks, clears err_cnt, fail_* and cyc_cnt, and moves to HOLD.
- HOLD:
  - proc_reset = 1 for exactly RST_CYCLES cycles, then RUN.
- RUN:
  - proc_reset = 0.
  - cyc_cnt increments each cycle, saturating at all-ones.
  - Moves to CHECK when cyc_cnt == budget-1.
  - budget == 0: HOLD goes straight to CHECK and the processor never leaves reset.
- CHECK (pipelined, one entry per cycle):
  - Cycle k drives rf_raddr = table[k].reg.
  - Cycle k+1 compares (rf_rdata ^ table[k].val) & table[k].mask.
  - Nonzero result: err_cnt increments. On the first mismatch only, fail_idx and fail_got are captured.
  - proc_reset stays 0 so the RF stays readable; the processor keeps running.
  - After the last compare, go to DONE. Total CHECK latency = num_checks + 1 cycles.
  - num_checks == 0: DONE after 1 cycle with pass = 1.
  - num_checks > MAX_CHECKS: clamped to MAX_CHECKS.
- DONE:
  - done = 1. Results hold. proc_reset = 1.
  - start begins a new run (same rules as IDLE).
  - exp_we is accepted.
- Ignored events:
  - start while busy.
  - exp_we while busy.
- abort: any state goes to IDLE next cycle with proc_reset = 1. Results are cleared.
- Same-cycle start and abort: abort wins.
- Asynchronous reset mid-run: immediate reset values; the table is preserved.

Decomposition:
- Shared package `bench_pkg`:
  - state enum {IDLE, HOLD, RUN, CHECK, DONE}.
  - Table entry struct {reg, val, mask}.
  - Width helper localparams.
- Sub-module `bench_expect_table`:
  - MAX_CHECKS-entry register array.
  - One synchronous write port and one combinational read port.
  - Keeps the FSM file small.

Test Plan:
1. Table {x1=16, x2=8, x3=24, x4=10}, mask all-ones, budget 12, RF model loaded with these values -> done after 2+12+5 cycles; pass=1; err_cnt=0; cyc_cnt=12.
2. Same run with RF x3=0x17 -> pass=0, err_cnt=1, fail_idx=2, fail_got=0x17.
3. x2 expected 0xFFFFFFFFFFFFFFF6 with mask 0xFFFF and RF value 0x000000000000FFF6 -> pass=1. With mask all-ones -> err_cnt=1.
4. Edge cases:
   - num_checks=0 -> done 1 cycle after RUN ends, pass=1.
   - budget=0 -> proc_reset never deasserts, cyc_cnt=0.
5. Interference during RUN:
   - abort mid-RUN at cycle 5 -> IDLE next cycle, proc_reset=1, done=0.
   - start pulsed during RUN is ignored and cyc_cnt is unaffected.
   - exp_we during CHECK leaves the table unchanged.
6. reset asserted during CHECK, then deasserted, then start -> the same table results reproduce (table retained); outputs read zero between reset and start.
